// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with occupancy count, threshold flags and
// overflow/underflow pulses. Define FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int AFULL_TH  = (2 ** ADDR_W) - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrreq,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rdreq,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   PTR_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   AFULL_C   = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AEMPTY_C  = AEMPTY_TH[ADDR_W:0];
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W:0]   wr_ptr_r;
    logic [ADDR_W:0]   rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_next_s;
    logic              overflow_r;
    logic              underflow_r;

    logic              full_s;
    logic              empty_s;
    logic              almost_full_s;
    logic              almost_empty_s;
    logic              wr_accept_s;
    logic              rd_accept_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [ADDR_W-1:0] rd_addr_s;

    // Status flags decoded from the registered occupancy.
    always_comb begin
        full_s         = (count_r == DEPTH_C);
        empty_s        = (count_r == PTR_ZERO);
        almost_full_s  = (count_r >= AFULL_C);
        almost_empty_s = (count_r <= AEMPTY_C);
    end

    // Request qualification; requests are ignored while reset is held low.
    always_comb begin
        wr_accept_s = rst & wrreq & ~full_s;
        rd_accept_s = rst & rdreq & ~empty_s;
        wr_addr_s   = wr_ptr_r[ADDR_W-1:0];
        rd_addr_s   = rd_ptr_r[ADDR_W-1:0];
    end

    // Occupancy update: a simultaneous accepted read and write cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_next_s = count_r + PTR_ONE;
            2'b01:   count_next_s = count_r - PTR_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, count and error pulses; pointers carry an extra wrap bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= PTR_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_accept_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            overflow_r  <= wrreq & full_s;
            underflow_r <= rdreq & empty_s;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_addr_s] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown directly; an accepted read simply advances the pointer.
    always_comb begin
        if (empty_s) begin
            data_out = DATA_ZERO;
        end else begin
            data_out = mem_r[rd_addr_s];
        end
    end
`else
    logic [DATA_W-1:0] data_out_r;

    // Registered read port: loads the head word on an accepted read, else holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out_r <= DATA_ZERO;
        end else if (rd_accept_s) begin
            data_out_r <= mem_r[rd_addr_s];
        end
    end

    // Drive the read data from its register.
    always_comb begin
        data_out = data_out_r;
    end
`endif

    // Output mapping.
    always_comb begin
        full         = full_s;
        empty        = empty_s;
        almost_full  = almost_full_s;
        almost_empty = almost_empty_s;
        count        = count_r;
        overflow     = overflow_r;
        underflow    = underflow_r;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 3; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter AFULL_TH, default DEPTH-2, almost-full threshold in entries; legal range 1..DEPTH.
REQ-004 Parameter AEMPTY_TH, default 1, almost-empty threshold in entries; legal range 0..DEPTH-1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 wrreq  in  1  write request.
REQ-008 data_in  in  DATA_W  write data.
REQ-009 rdreq  in  1  read request (read acknowledge in FWFT mode).
REQ-010 data_out  out  DATA_W  read data.
REQ-011 full  out  1  count == DEPTH.
REQ-012 empty  out  1  count == 0.
REQ-013 almost_full  out  1  count >= AFULL_TH.
REQ-014 almost_empty  out  1  count <= AEMPTY_TH.
REQ-015 count  out  ADDR_W+1  current number of stored entries, 0..DEPTH.
REQ-016 overflow  out  1  one-cycle pulse reporting a rejected write.
REQ-017 underflow  out  1  one-cycle pulse reporting a rejected read.

Function
REQ-018 Write accepted iff wrreq=1 and full=0; data_in is stored at mem[wrptr] and wrptr increments.
REQ-019 Read accepted iff rdreq=1 and empty=0; rdptr increments.
REQ-020 Both pointers are ADDR_W+1 bits, wrap modulo 2*DEPTH, and address memory with the low ADDR_W bits.
REQ-021 count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-022 Simultaneous requests when empty: write accepted, read rejected, underflow pulses, count becomes 1.
REQ-023 Simultaneous requests when full: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
REQ-024 full, empty, almost_full and almost_empty are combinational decodes of the registered count.
REQ-025 overflow is 1 in the cycle after a rejected write and 0 otherwise; underflow behaves the same for rejected reads.
REQ-026 Rejected requests do not change pointers, count or memory.
REQ-027 Standard mode: on an accepted read, data_out loads mem[rdptr] at the same edge (1-cycle latency); otherwise data_out holds its value.
REQ-028 Order is strictly first-in first-out across pointer wrap-around.

Reset
REQ-029 While rst=0 at a clock edge: wrptr, rdptr and count are cleared to 0; data_out=0, overflow=0, underflow=0; therefore empty=1, almost_empty=1, full=0, almost_full=0.
REQ-030 wrreq and rdreq are ignored in any cycle where rst=0; reset during traffic discards all contents.
REQ-031 Memory array contents are not reset.

Configuration
REQ-032 Macro FIFO_FWFT_EN: when defined, first-word fall-through: data_out = mem[rdptr] combinationally while empty=0, and 0 while empty=1; rdreq pops the displayed word; REQ-027 does not apply.
REQ-033 Without FIFO_FWFT_EN, standard registered-read behaviour per REQ-027 applies.

Verification (DATA_W=8, ADDR_W=3)
REQ-034 Reset, then 8 writes 0x01..0x08 -> count=8, full=1, almost_full asserted from count=6; 9th write 0xFF -> overflow pulse, contents unchanged.
REQ-035 From full, 8 reads -> data 0x01..0x08 in order (standard mode: one cycle after each rdreq); then rdreq on empty -> underflow pulse, data_out holds 0x08.
REQ-036 Wrap: write 5, read 5, write 8 (0x10..0x17), read 8 -> data 0x10..0x17, count returns to 0.
REQ-037 Simultaneous wrreq+rdreq at count=0, 4 and 8 -> count becomes 1, 4 and 7 respectively, with the underflow/overflow pulses of REQ-022/023.
REQ-038 rst=0 for one cycle at count=5 -> next cycle count=0, empty=1, data_out=0; later reads return only data written after reset.
REQ-039 FIFO_FWFT_EN defined: single write 0xA5 -> data_out=0xA5 in the next cycle without rdreq; rdreq -> empty=1, data_out=0.
